// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order word reads at the current PC, tracks in-flight
// requests with a pending-PC FIFO and buffers returned words for decode.
module instruction_fetch_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_adv_o,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic            id_fault_o
);

    localparam int unsigned     AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     NOP   = 32'h0000_0013;
    localparam logic [AW+1:0]   LIMIT = (AW+2)'(DEPTH);
    localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] pend_pc [DEPTH];
    logic [AW-1:0]   pend_wr, pend_rd;
    logic [AW:0]     inflight, inflight_next;

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic            q_fault [DEPTH];
    logic [AW-1:0]   q_wr, q_rd;
    logic [AW:0]     count, count_next;

    logic            misaligned, credit, flushing, accept, rsp, rsp_keep;
    logic            fault_push, q_push, q_pop;
    logic [31:0]     push_instr;
    logic [XLEN-1:0] push_pc;
    logic            push_fault;

    assign misaligned = pc_i[1:0] != 2'b00;
    assign credit     = ({1'b0, inflight} + {1'b0, count}) < LIMIT;
    assign flushing   = flush_i && (state != BOOT);
    assign rsp        = imem_rsp_valid_i && (inflight != '0);

    assign imem_req_valid_o = (state == RUN) && !flush_i && !misaligned && credit;
    assign accept           = imem_req_valid_o && imem_req_ready_i;
    assign pc_adv_o         = accept;
    assign imem_addr_o      = pc_i;

    // Responses only land in the queue while running; in DRAIN or on a flush
    // edge they are retired against the pending FIFO and discarded.
    assign rsp_keep   = rsp && (state == RUN) && !flush_i;
    assign fault_push = (state == RUN) && !flush_i && misaligned &&
                        (inflight == '0) && (count < FULL);
    assign q_push     = rsp_keep || fault_push;
    assign q_pop      = id_valid_o && id_ready_i && !flushing;

    always_comb begin
        push_instr = NOP;
        push_pc    = pc_i;
        push_fault = 1'b1;
        if (!fault_push) begin
            push_instr = imem_rsp_err_i ? NOP : imem_rsp_data_i;
            push_pc    = pend_pc[pend_rd];
            push_fault = imem_rsp_err_i;
        end
    end

    always_comb begin
        inflight_next = inflight;
        if (accept && !rsp)
            inflight_next = inflight + (AW+1)'(1);
        else if (!accept && rsp)
            inflight_next = inflight - (AW+1)'(1);
    end

    always_comb begin
        count_next = count;
        if (flushing)
            count_next = '0;
        else if (q_push && !q_pop)
            count_next = count + (AW+1)'(1);
        else if (!q_push && q_pop)
            count_next = count - (AW+1)'(1);
    end

    always_comb begin
        state_next = state;
        if (flushing) begin
            state_next = (inflight_next != '0) ? DRAIN : RUN;
        end else begin
            case (state)
                BOOT:    state_next = RUN;
                RUN:     if (fault_push) state_next = HALT;
                HALT:    state_next = HALT;
                DRAIN:   if (inflight_next == '0) state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= BOOT;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_wr  <= '0;
            pend_rd  <= '0;
            inflight <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                pend_pc[i] <= '0;
        end else begin
            if (accept) begin
                pend_pc[pend_wr] <= pc_i;
                pend_wr          <= pend_wr + AW'(1);
            end
            if (rsp)
                pend_rd <= pend_rd + AW'(1);
            inflight <= inflight_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_wr  <= '0;
            q_rd  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_fault[i] <= 1'b0;
            end
        end else begin
            if (flushing) begin
                q_wr <= '0;
                q_rd <= '0;
            end else begin
                if (q_push) begin
                    q_instr[q_wr] <= push_instr;
                    q_pc[q_wr]    <= push_pc;
                    q_fault[q_wr] <= push_fault;
                    q_wr          <= q_wr + AW'(1);
                end
                if (q_pop)
                    q_rd <= q_rd + AW'(1);
            end
            count <= count_next;
        end
    end

    assign id_valid_o = count != '0;
    assign id_instr_o = id_valid_o ? q_instr[q_rd] : '0;
    assign id_pc_o    = id_valid_o ? q_pc[q_rd]    : '0;
    assign id_fault_o = id_valid_o && q_fault[q_rd];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: models the PC register and a latency-1
// instruction memory, then checks a per-cycle vector table and corner sequences.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_adv_o;
    logic        flush;
    logic        imem_req_valid_o;
    logic        req_ready;
    logic [31:0] imem_addr_o;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        id_valid_o;
    logic        id_ready;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_fault_o;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .pc_adv_o(pc_adv_o), .flush_i(flush),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(req_ready),
        .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(rsp_valid),
        .imem_rsp_data_i(rsp_data), .imem_rsp_err_i(rsp_err),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready), .id_instr_o(id_instr_o),
        .id_pc_o(id_pc_o), .id_fault_o(id_fault_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    typedef struct {
        logic        id_rdy;
        logic        rq_rdy;
        logic        rv;
        logic        adv;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] idpc;
    } vec_t;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          acc_count;
    logic        hold;
    logic [31:0] err_addr;
    logic [31:0] pend[$];
    entry_t      popped[$];
    vec_t        vecs[8];
    logic        got;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic drive_rsp();
        if (!hold && pend.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = memf(pend[0]);
            rsp_err   = (pend[0] == err_addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_err   = 1'b0;
        end
    endtask

    // Called just before a rising edge; applies model updates #1 after it.
    task automatic tick();
        logic        acc, adv, rsp, pop;
        logic [31:0] a;
        entry_t      e;
        acc     = imem_req_valid_o && req_ready;
        adv     = pc_adv_o;
        a       = imem_addr_o;
        rsp     = rsp_valid;
        pop     = id_valid_o && id_ready;
        e.pc    = id_pc_o;
        e.instr = id_instr_o;
        e.fault = id_fault_o;
        @(posedge clk);
        #1;
        if (rsp) void'(pend.pop_front());
        if (acc) begin
            pend.push_back(a);
            acc_count++;
        end
        if (adv) pc = pc + 32'd4;
        if (pop) popped.push_back(e);
        drive_rsp();
    endtask

    task automatic cyc();
        @(negedge clk);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; hold = 1'b0; req_ready = 1'b1; id_ready = 1'b1;
        err_addr = 32'hFFFF_FFFF; pc = 32'h40; acc_count = 0;
        pend.delete(); popped.delete();
        drive_rsp();
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_pc_adv", 32'(pc_adv_o), 32'd0);
        chk("rst_id_valid", 32'(id_valid_o), 32'd0);
        chk("rst_id_instr", id_instr_o, 32'd0);
        chk("rst_id_pc", id_pc_o, 32'd0);
        chk("rst_id_fault", 32'(id_fault_o), 32'd0);
        chk("rst_addr_follows_pc", imem_addr_o, 32'h40);
        pc = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Steady stream from reset: BOOT gap, then two fetches per three cycles at DEPTH=2.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h8};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            id_ready  = vecs[i].id_rdy;
            req_ready = vecs[i].rq_rdy;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid_o), 32'(vecs[i].rv));
            chk($sformatf("v%0d_pc_adv", i), 32'(pc_adv_o), 32'(vecs[i].adv));
            chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_id_valid", i), 32'(id_valid_o), 32'(vecs[i].idv));
            if (vecs[i].idv) begin
                chk($sformatf("v%0d_id_pc", i), id_pc_o, vecs[i].idpc);
                chk($sformatf("v%0d_id_instr", i), id_instr_o, memf(vecs[i].idpc));
                chk($sformatf("v%0d_id_fault", i), 32'(id_fault_o), 32'd0);
            end
            tick();
        end

        // Decode stalled: credit limit caps fetches at DEPTH, then resume in order.
        do_reset();
        id_ready = 1'b0;
        repeat (10) cyc();
        @(negedge clk);
        chk("stall_accepts", 32'(acc_count), 32'd2);
        chk("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("stall_pc_adv", 32'(pc_adv_o), 32'd0);
        chk("stall_id_pc", id_pc_o, 32'h0);
        tick();
        id_ready = 1'b1;
        repeat (12) cyc();
        chk("resume_pops_ge6", 32'(popped.size() >= 6), 32'd1);
        for (int i = 0; i < popped.size(); i++) begin
            chk($sformatf("resume_pc%0d", i), popped[i].pc, 32'(4 * i));
            chk($sformatf("resume_instr%0d", i), popped[i].instr, memf(32'(4 * i)));
        end

        // Memory not ready for three cycles: address held, one fetch on accept.
        do_reset();
        req_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("nrdy%0d_req_valid", i), 32'(imem_req_valid_o), 32'd1);
            chk($sformatf("nrdy%0d_pc_adv", i), 32'(pc_adv_o), 32'd0);
            chk($sformatf("nrdy%0d_addr", i), imem_addr_o, 32'h0);
            tick();
        end
        req_ready = 1'b1;
        @(negedge clk);
        chk("nrdy_accept_adv", 32'(pc_adv_o), 32'd1);
        tick();
        req_ready = 1'b0;
        @(negedge clk);
        chk("nrdy_single_fetch", 32'(acc_count), 32'd1);
        chk("nrdy_next_addr", imem_addr_o, 32'h4);
        tick();

        // Flush with a full queue and nothing in flight: queue cleared, refetch at 0x100.
        do_reset();
        id_ready = 1'b0;
        repeat (6) cyc();
        flush = 1'b1;
        pc = 32'h100;
        @(negedge clk);
        chk("flushq_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("flushq_pc_adv", 32'(pc_adv_o), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flushq_id_valid", 32'(id_valid_o), 32'd0);
        chk("flushq_req_valid_after", 32'(imem_req_valid_o), 32'd1);
        chk("flushq_addr_after", imem_addr_o, 32'h100);
        tick();

        // Flush with two fetches in flight: late responses dropped during DRAIN.
        do_reset();
        hold = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("drain_credit_stall", 32'(imem_req_valid_o), 32'd0);
        tick();
        flush = 1'b1;
        pc = 32'h100;
        popped.delete();
        @(negedge clk);
        chk("drain_flush_req", 32'(imem_req_valid_o), 32'd0);
        tick();
        flush = 1'b0;
        hold = 1'b0;
        drive_rsp();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_req_valid", i), 32'(imem_req_valid_o), 32'd0);
            chk($sformatf("drain%0d_id_valid", i), 32'(id_valid_o), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("drain_resume_valid", 32'(imem_req_valid_o), 32'd1);
        chk("drain_resume_addr", imem_addr_o, 32'h100);
        tick();
        repeat (6) cyc();
        chk("drain_pops_ge1", 32'(popped.size() >= 1), 32'd1);
        if (popped.size() > 0) begin
            chk("drain_first_pc", popped[0].pc, 32'h100);
            chk("drain_first_instr", popped[0].instr, memf(32'h100));
        end

        // Access fault on 0x8, then a misaligned PC producing one fault entry and HALT.
        do_reset();
        err_addr = 32'h8;
        repeat (12) cyc();
        chk("err_pops_ge3", 32'(popped.size() >= 3), 32'd1);
        if (popped.size() >= 3) begin
            chk("err_ok_fault", 32'(popped[1].fault), 32'd0);
            chk("err_pc", popped[2].pc, 32'h8);
            chk("err_instr", popped[2].instr, 32'h0000_0013);
            chk("err_fault", 32'(popped[2].fault), 32'd1);
        end
        flush = 1'b1;
        pc = 32'h102;
        @(negedge clk);
        tick();
        flush = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (id_valid_o) got = 1'b1;
            else tick();
        end
        chk("mis_fault_seen", 32'(got), 32'd1);
        if (got) begin
            chk("mis_pc", id_pc_o, 32'h102);
            chk("mis_instr", id_instr_o, 32'h0000_0013);
            chk("mis_fault", 32'(id_fault_o), 32'd1);
            chk("mis_no_req", 32'(imem_req_valid_o), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_req_valid", i), 32'(imem_req_valid_o), 32'd0);
            chk($sformatf("halt%0d_pc_adv", i), 32'(pc_adv_o), 32'd0);
            chk($sformatf("halt%0d_id_valid", i), 32'(id_valid_o), 32'd0);
            tick();
        end
        flush = 1'b1;
        pc = 32'h200;
        @(negedge clk);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("halt_exit_valid", 32'(imem_req_valid_o), 32'd1);
        chk("halt_exit_addr", imem_addr_o, 32'h200);
        tick();

        // Asynchronous reset mid-stream with a full queue, then the BOOT gap again.
        do_reset();
        id_ready = 1'b0;
        repeat (8) cyc();
        @(negedge clk);
        chk("arst_pre_full", 32'(id_valid_o), 32'd1);
        #2;
        rst = 1'b0;
        pc = 32'h0;
        pend.delete();
        popped.delete();
        acc_count = 0;
        drive_rsp();
        #1;
        chk("arst_id_valid", 32'(id_valid_o), 32'd0);
        chk("arst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("arst_pc_adv", 32'(pc_adv_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        chk("arst_boot_gap", 32'(imem_req_valid_o), 32'd0);
        tick();
        @(negedge clk);
        chk("arst_first_req", 32'(imem_req_valid_o), 32'd1);
        chk("arst_first_addr", imem_addr_o, 32'h0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
